// File: rtl/processor.sv
// Five-stage 16-bit pipelined processor: instruction ROM, data RAM and CPU core.
// Pipeline runs IF -> ID -> EX -> MEM -> WB with no forwarding or interlock.
// Branches resolve in EX. A taken branch or jump squashes the IF and ID slots.

module processor_imem (
   input  logic [7:0]  addr,
   output logic [15:0] data
);
   // Contents are loaded from outside the design; there is no write path.
   logic [15:0] ram [0:255];

   assign data = ram[addr];
endmodule

module processor_dmem (
   input  logic        clock,
   input  logic        we,
   input  logic [7:0]  addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata
);
   logic [15:0] ram [0:255];

   assign rdata = ram[addr];

   // Synchronous write port; the array is deliberately not reset.
   always_ff @(posedge clock) begin
      if (we) ram[addr] <= wdata;
   end
endmodule

// state  | meaning
// S_IDLE | pipeline frozen, waiting for start with enable high
// S_EXEC | pipeline advances on every cycle that enable is high
module processor_cpu (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        enable,
   input  logic [3:0]  select_y,
   input  logic [15:0] i_datain,
   input  logic [15:0] d_rdata,
   output logic [7:0]  i_addr,
   output logic        d_we,
   output logic [7:0]  d_addr,
   output logic [15:0] d_wdata,
   output logic [15:0] y
);
   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_HALT  = 5'b00001;
   localparam logic [4:0] OP_LOAD  = 5'b00010;
   localparam logic [4:0] OP_STORE = 5'b00011;
   localparam logic [4:0] OP_ADD   = 5'b01000;
   localparam logic [4:0] OP_ADDI  = 5'b01001;
   localparam logic [4:0] OP_SUB   = 5'b01010;
   localparam logic [4:0] OP_CMP   = 5'b01011;
   localparam logic [4:0] OP_AND   = 5'b01100;
   localparam logic [4:0] OP_OR    = 5'b01101;
   localparam logic [4:0] OP_XOR   = 5'b01110;
   localparam logic [4:0] OP_SLL   = 5'b01111;
   localparam logic [4:0] OP_SRL   = 5'b10000;
   localparam logic [4:0] OP_LDIH  = 5'b10001;
   localparam logic [4:0] OP_JUMP  = 5'b11000;
   localparam logic [4:0] OP_BZ    = 5'b11001;
   localparam logic [4:0] OP_BNZ   = 5'b11010;
   localparam logic [4:0] OP_BN    = 5'b11011;
   localparam logic [4:0] OP_BC    = 5'b11100;

   typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

   state_t      state;
   logic [7:0]  pc;
   logic [15:0] id_ir;
   // Past ID only the opcode and destination field are needed: {op, r1}.
   logic [7:0]  ex_ir, mem_ir, wb_ir;
   logic [15:0] gr [0:7];
   logic [15:0] reg_A, reg_B, reg_C, reg_C1, smdr, smdr1;
   logic        zf, nf, cf;

   logic [4:0]  id_op, ex_op, mem_op, wb_op;
   logic [2:0]  id_r1, id_r2, id_r3, wb_r1;
   logic [7:0]  id_imm8;
   logic [15:0] op_a, op_b;
   logic [16:0] sum, diff;
   logic [15:0] alu_out;
   logic        alu_cf, alu_upd, taken, wb_writes, advance;

   assign id_op   = id_ir[15:11];
   assign id_r1   = id_ir[10:8];
   assign id_r2   = id_ir[6:4];
   assign id_r3   = id_ir[2:0];
   assign id_imm8 = id_ir[7:0];
   assign ex_op   = ex_ir[7:3];
   assign mem_op  = mem_ir[7:3];
   assign wb_op   = wb_ir[7:3];
   assign wb_r1   = wb_ir[2:0];

   assign advance = (state == S_EXEC) && enable;
   assign i_addr  = pc;
   assign d_addr  = reg_C[7:0];
   assign d_wdata = smdr1;
   assign d_we    = advance && (mem_op == OP_STORE);

   // Operand selection at ID; gr0 is an ordinary register, not hardwired.
   always_comb begin
      op_a = gr[id_r2];
      op_b = gr[id_r3];
      case (id_op)
         OP_ADDI, OP_BZ, OP_BNZ, OP_BN, OP_BC: begin
            op_a = gr[id_r1];
            op_b = {8'h00, id_imm8};
         end
         OP_LDIH: begin
            op_a = gr[id_r1];
            op_b = {id_imm8, 8'h00};
         end
         OP_JUMP: begin
            op_a = 16'h0000;
            op_b = {8'h00, id_imm8};
         end
         OP_LOAD, OP_STORE, OP_SLL, OP_SRL: op_b = {12'h000, id_ir[3:0]};
         default: ;
      endcase
   end

   assign sum  = {1'b0, reg_A} + {1'b0, reg_B};
   assign diff = {1'b0, reg_A} - {1'b0, reg_B};

   // EX-stage ALU; address and branch-target adds do not touch the flags.
   always_comb begin
      alu_out = 16'h0000;
      alu_cf  = 1'b0;
      alu_upd = 1'b0;
      case (ex_op)
         OP_LOAD, OP_STORE, OP_JUMP, OP_BZ, OP_BNZ, OP_BN, OP_BC: alu_out = sum[15:0];
         OP_ADD, OP_ADDI, OP_LDIH: begin
            alu_out = sum[15:0];
            alu_cf  = sum[16];
            alu_upd = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            alu_out = diff[15:0];
            alu_cf  = diff[16];
            alu_upd = 1'b1;
         end
         OP_AND: begin alu_out = reg_A & reg_B;        alu_upd = 1'b1; end
         OP_OR:  begin alu_out = reg_A | reg_B;        alu_upd = 1'b1; end
         OP_XOR: begin alu_out = reg_A ^ reg_B;        alu_upd = 1'b1; end
         OP_SLL: begin alu_out = reg_A << reg_B[3:0];  alu_upd = 1'b1; end
         OP_SRL: begin alu_out = reg_A >> reg_B[3:0];  alu_upd = 1'b1; end
         default: ;
      endcase
   end

   // Branch decision in EX against the flags left by the previous ALU op.
   always_comb begin
      case (ex_op)
         OP_JUMP: taken = 1'b1;
         OP_BZ:   taken = zf;
         OP_BNZ:  taken = !zf;
         OP_BN:   taken = nf;
         OP_BC:   taken = cf;
         default: taken = 1'b0;
      endcase
   end

   // Ops that retire a result into gr[r1].
   always_comb begin
      case (wb_op)
         OP_LOAD, OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_SLL, OP_SRL, OP_LDIH: wb_writes = 1'b1;
         default:                         wb_writes = 1'b0;
      endcase
   end

   // Run-state FSM and the whole pipeline advance under one clocked block.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         pc     <= 8'h00;
         id_ir  <= {OP_NOP, 11'h000};
         ex_ir  <= {OP_NOP, 3'h0};
         mem_ir <= {OP_NOP, 3'h0};
         wb_ir  <= {OP_NOP, 3'h0};
         reg_A  <= 16'h0000;
         reg_B  <= 16'h0000;
         reg_C  <= 16'h0000;
         reg_C1 <= 16'h0000;
         smdr   <= 16'h0000;
         smdr1  <= 16'h0000;
         zf     <= 1'b0;
         nf     <= 1'b0;
         cf     <= 1'b0;
         for (int i = 0; i < 8; i++) gr[i] <= 16'h0000;
      end else if (state == S_IDLE) begin
         if (enable && start) state <= S_EXEC;
      end else if (enable) begin
         if (ex_op == OP_HALT) state <= S_IDLE;
         if (taken) begin
            pc    <= alu_out[7:0];
            id_ir <= {OP_NOP, 11'h000};
            ex_ir <= {OP_NOP, 3'h0};
         end else begin
            pc    <= pc + 8'd1;
            id_ir <= i_datain;
            ex_ir <= {id_op, id_r1};
         end
         reg_A  <= op_a;
         reg_B  <= op_b;
         smdr   <= gr[id_r1];
         mem_ir <= ex_ir;
         reg_C  <= alu_out;
         smdr1  <= smdr;
         wb_ir  <= mem_ir;
         reg_C1 <= (mem_op == OP_LOAD) ? d_rdata : reg_C;
         if (alu_upd) begin
            zf <= (alu_out == 16'h0000);
            nf <= alu_out[15];
            cf <= alu_cf;
         end
         if (wb_writes) gr[wb_r1] <= reg_C1;
      end
   end

   // Debug read-out mux.
   always_comb begin
      case (select_y)
         4'd0, 4'd1, 4'd2, 4'd3,
         4'd4, 4'd5, 4'd6, 4'd7: y = gr[select_y[2:0]];
         4'd8:    y = reg_A;
         4'd9:    y = reg_B;
         4'd10:   y = alu_out;
         4'd11:   y = {8'h00, pc};
         4'd12:   y = i_datain;
         4'd13:   y = {13'h0000, zf, nf, cf};
         default: y = 16'h0000;
      endcase
   end
endmodule

module processor (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        enable,
   input  logic [3:0]  select_y,
   output logic [15:0] y
);
   logic [7:0]  i_addr;
   logic [15:0] i_datain;
   logic        d_we;
   logic [7:0]  d_addr;
   logic [15:0] d_wdata, d_rdata;

   processor_imem imem (
      .addr (i_addr),
      .data (i_datain)
   );

   processor_dmem dmem (
      .clock (clock),
      .we    (d_we),
      .addr  (d_addr),
      .wdata (d_wdata),
      .rdata (d_rdata)
   );

   processor_cpu pcpu (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .enable   (enable),
      .select_y (select_y),
      .i_datain (i_datain),
      .d_rdata  (d_rdata),
      .i_addr   (i_addr),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .y        (y)
   );
endmodule

// File: tb/tb_processor.sv
// Directed bench for the pipelined processor: programs are placed in imem
// through the hierarchy and results are read through the debug port.
module tb_processor;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  select_y = 4'd0;
   logic [15:0] y;
   int          vectors = 0;
   int          miscompares = 0;

   processor dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .enable   (enable),
      .select_y (select_y),
      .y        (y)
   );

   always #5 clock = ~clock;

   // LDIH gr3,12 ; 3xNOP ; ADDI gr3,34 ; 2xNOP ; HALT
   localparam logic [15:0] PROG_BUILD [16] = '{
      16'h8B12, 16'h0000, 16'h0000, 16'h0000, 16'h4B34, 16'h0000, 16'h0000, 16'h0800,
      16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
   // ADDI gr2,AA ; STORE gr2->[5] ; LOAD gr1<-[5] ; ADD gr3=gr1+gr1 ; STORE gr3->[6] ; HALT
   localparam logic [15:0] PROG_MEM [16] = '{
      16'h4AAA, 16'h0000, 16'h0000, 16'h0000, 16'h1A05, 16'h1105, 16'h0000, 16'h0000,
      16'h0000, 16'h4311, 16'h0000, 16'h0000, 16'h0000, 16'h1B06, 16'h0000, 16'h0800};
   // gr1=FFFF ; ADDI gr1,1 ; BZ gr0+13 ; three shadow ADDIs that must not retire ; HALT
   localparam logic [15:0] PROG_BZ [16] = '{
      16'h89FF, 16'h0000, 16'h0000, 16'h0000, 16'h49FF, 16'h0000, 16'h0000, 16'h0000,
      16'h4901, 16'hC80D, 16'h4A11, 16'h4C22, 16'h4D33, 16'h0000, 16'h0000, 16'h0800};
   // LDIH gr1 ; ADDI gr2 ; SUB ; SRL ; OR ; XOR ; SLL ; BZ (not taken) ; ADDI gr2 ; CMP ; HALT
   localparam logic [15:0] PROG_ALU [16] = '{
      16'h8912, 16'h4A0F, 16'h0000, 16'h0000, 16'h0000, 16'h5312, 16'h8418, 16'h6D12,
      16'h7612, 16'h7F24, 16'hC800, 16'h4A01, 16'h5831, 16'h0000, 16'h0000, 16'h0800};
   localparam logic [15:0] ALU_EXP [8] = '{
      16'h0000, 16'h1200, 16'h0010, 16'h11F1, 16'h0012, 16'h120F, 16'h120F, 16'h00F0};

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic peek(input logic [3:0] s, output logic [15:0] v);
      select_y = s;
      #1;
      v = y;
   endtask

   task automatic load_prog(input logic [15:0] p [16]);
      for (int i = 0; i < 256; i++) dut.imem.ram[i] = 16'h0000;
      for (int i = 0; i < 16; i++) dut.imem.ram[i] = p[i];
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      enable = 1'b0;
      #2;
      reset = 1'b0;
      tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      enable = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output logic done);
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (int'(dut.pcpu.state) == 0) begin
            done = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [15:0] v, exp;
      load_prog(PROG_BUILD);
      reset = 1'b1;
      #2;
      for (int s = 0; s < 16; s++) begin
         peek(s[3:0], v);
         exp = (s == 12) ? 16'h8B12 : 16'h0000;
         vectors++;
         if (v !== exp) begin
            miscompares++;
            $display("FAIL reset_y%0d: got %h, expected %h", s, v, exp);
         end
      end
      vectors++;
      if (int'(dut.pcpu.state) != 0) begin
         miscompares++;
         $display("FAIL reset_state: got %0d, expected 0", int'(dut.pcpu.state));
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_build();
      logic [15:0] v;
      logic done;
      load_prog(PROG_BUILD);
      do_reset();
      pulse_start();
      wait_idle(40, done);
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL build_halt: got running, expected idle within 40 cycles");
      end
      peek(4'd3, v);
      vectors++;
      if (v !== 16'h1234) begin
         miscompares++;
         $display("FAIL build_gr3: got %h, expected 1234", v);
      end
      peek(4'd11, v);
      vectors++;
      if (v !== 16'h000A) begin
         miscompares++;
         $display("FAIL build_pc: got %h, expected 000a", v);
      end
   endtask

   task automatic test_load_store();
      logic [15:0] v;
      logic done;
      load_prog(PROG_MEM);
      do_reset();
      pulse_start();
      wait_idle(40, done);
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL mem_halt: got running, expected idle within 40 cycles");
      end
      vectors++;
      if (dut.dmem.ram[6] !== 16'h0154) begin
         miscompares++;
         $display("FAIL mem_dmem6: got %h, expected 0154", dut.dmem.ram[6]);
      end
      peek(4'd1, v);
      vectors++;
      if (v !== 16'h00AA) begin
         miscompares++;
         $display("FAIL mem_gr1: got %h, expected 00aa", v);
      end
      peek(4'd3, v);
      vectors++;
      if (v !== 16'h0154) begin
         miscompares++;
         $display("FAIL mem_gr3: got %h, expected 0154", v);
      end
   endtask

   task automatic test_branch();
      logic [15:0] v;
      logic done;
      load_prog(PROG_BZ);
      do_reset();
      pulse_start();
      wait_idle(40, done);
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL bz_halt: got running, expected idle within 40 cycles");
      end
      for (int s = 0; s < 8; s++) begin
         peek(s[3:0], v);
         vectors++;
         if (v !== 16'h0000) begin
            miscompares++;
            $display("FAIL bz_gr%0d: got %h, expected 0000", s, v);
         end
      end
      peek(4'd13, v);
      vectors++;
      if (v !== 16'h0005) begin
         miscompares++;
         $display("FAIL bz_flags: got %h, expected 0005", v);
      end
      peek(4'd11, v);
      vectors++;
      if (v !== 16'h0012) begin
         miscompares++;
         $display("FAIL bz_pc: got %h, expected 0012", v);
      end
   endtask

   task automatic test_alu();
      logic [15:0] v;
      logic done;
      load_prog(PROG_ALU);
      do_reset();
      pulse_start();
      wait_idle(40, done);
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL alu_halt: got running, expected idle within 40 cycles");
      end
      for (int s = 0; s < 8; s++) begin
         peek(s[3:0], v);
         vectors++;
         if (v !== ALU_EXP[s]) begin
            miscompares++;
            $display("FAIL alu_gr%0d: got %h, expected %h", s, v, ALU_EXP[s]);
         end
      end
      peek(4'd13, v);
      vectors++;
      if (v !== 16'h0003) begin
         miscompares++;
         $display("FAIL alu_flags: got %h, expected 0003", v);
      end
   endtask

   task automatic test_freeze();
      logic [15:0] v;
      logic done;
      load_prog(PROG_BUILD);
      do_reset();
      pulse_start();
      repeat (6) tick();
      enable = 1'b0;
      repeat (5) tick();
      peek(4'd11, v);
      vectors++;
      if (v !== 16'h0006) begin
         miscompares++;
         $display("FAIL freeze_pc: got %h, expected 0006", v);
      end
      peek(4'd3, v);
      vectors++;
      if (v !== 16'h1200) begin
         miscompares++;
         $display("FAIL freeze_gr3: got %h, expected 1200", v);
      end
      peek(4'd8, v);
      vectors++;
      if (v !== 16'h1200) begin
         miscompares++;
         $display("FAIL freeze_reg_a: got %h, expected 1200", v);
      end
      peek(4'd9, v);
      vectors++;
      if (v !== 16'h0034) begin
         miscompares++;
         $display("FAIL freeze_reg_b: got %h, expected 0034", v);
      end
      peek(4'd10, v);
      vectors++;
      if (v !== 16'h1234) begin
         miscompares++;
         $display("FAIL freeze_ex_result: got %h, expected 1234", v);
      end
      enable = 1'b1;
      wait_idle(40, done);
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL freeze_halt: got running, expected idle within 40 cycles");
      end
      peek(4'd3, v);
      vectors++;
      if (v !== 16'h1234) begin
         miscompares++;
         $display("FAIL freeze_final_gr3: got %h, expected 1234", v);
      end
      peek(4'd11, v);
      vectors++;
      if (v !== 16'h000A) begin
         miscompares++;
         $display("FAIL freeze_final_pc: got %h, expected 000a", v);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] v;
      logic done;
      load_prog(PROG_BUILD);
      do_reset();
      pulse_start();
      repeat (8) tick();
      peek(4'd3, v);
      vectors++;
      if (v !== 16'h1200) begin
         miscompares++;
         $display("FAIL midrst_pre_gr3: got %h, expected 1200", v);
      end
      reset = 1'b1;
      #1;
      peek(4'd3, v);
      vectors++;
      if (v !== 16'h0000) begin
         miscompares++;
         $display("FAIL midrst_gr3: got %h, expected 0000", v);
      end
      peek(4'd8, v);
      vectors++;
      if (v !== 16'h0000) begin
         miscompares++;
         $display("FAIL midrst_reg_a: got %h, expected 0000", v);
      end
      peek(4'd11, v);
      vectors++;
      if (v !== 16'h0000) begin
         miscompares++;
         $display("FAIL midrst_pc: got %h, expected 0000", v);
      end
      vectors++;
      if (int'(dut.pcpu.state) != 0) begin
         miscompares++;
         $display("FAIL midrst_state: got %0d, expected 0", int'(dut.pcpu.state));
      end
      vectors++;
      if (dut.dmem.ram[6] !== 16'h0154) begin
         miscompares++;
         $display("FAIL midrst_dmem6: got %h, expected 0154", dut.dmem.ram[6]);
      end
      reset = 1'b0;
      enable = 1'b1;
      repeat (10) tick();
      peek(4'd11, v);
      vectors++;
      if (v !== 16'h0000) begin
         miscompares++;
         $display("FAIL midrst_no_restart_pc: got %h, expected 0000", v);
      end
      pulse_start();
      wait_idle(40, done);
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_halt: got running, expected idle within 40 cycles");
      end
      peek(4'd3, v);
      vectors++;
      if (v !== 16'h1234) begin
         miscompares++;
         $display("FAIL midrst_final_gr3: got %h, expected 1234", v);
      end
   endtask

   initial begin
      test_reset();
      test_build();
      test_load_store();
      test_branch();
      test_alu();
      test_freeze();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
